// File: rtl/xbar_egress_fifo.sv
// xbar_egress_fifo: first-word-fall-through egress buffer for one crossbar
// master port. Holds {last,id,data} beats and, in packet mode, only exposes
// the head once a complete packet is stored (or the buffer is full).
module xbar_egress_fifo #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_ID___WIDTH = 3,
    parameter int DEPTH        = 8,
    parameter int PACKET_MODE  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [T_DATA_WIDTH-1:0]    s_data_i,
    input  logic [T_ID___WIDTH-1:0]    s_id_i,
    input  logic                       s_last_i,
    input  logic                       s_valid_i,
    output logic                       s_ready_o,
    output logic [T_DATA_WIDTH-1:0]    m_data_o,
    output logic [T_ID___WIDTH-1:0]    m_id_o,
    output logic                       m_last_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [$clog2(DEPTH):0]     pkt_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = T_DATA_WIDTH + T_ID___WIDTH + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
    // Set while a packet is partway out, so its tail is never re-gated.
    logic          drain_q, drain_d;
    logic          wr_en, rd_en, wr_last, rd_last, gate_open;
    logic [EW-1:0] head;

    // The "rst_n" port is active-high: the input side is closed while it is asserted.
    assign s_ready_o = ~rst_n & (level_q != FULL_LVL);
    assign wr_en     = s_valid_i & s_ready_o;
    assign rd_en     = m_valid_o & m_ready_i;
    assign wr_last   = wr_en & s_last_i;
    assign rd_last   = rd_en & m_last_o;

    assign head = mem_q[rd_ptr_q];
    assign {m_last_o, m_id_o, m_data_o} = head;

    assign level_o   = level_q;
    assign pkt_cnt_o = pkt_cnt_q;

    // Head presentation: cut-through shows any stored beat; packet mode waits for
    // a complete packet, a full buffer (oversize packet escape) or an ongoing drain.
    always_comb begin
        gate_open = 1'b1;
        if (PACKET_MODE != 0) begin
            gate_open = (pkt_cnt_q != '0) | (level_q == FULL_LVL) | drain_q;
        end
        m_valid_o = (level_q != '0) & gate_open;
    end

    // Next-state for pointers, occupancy, packet count and drain tracking.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;
        drain_d   = drain_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);

        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        pkt_cnt_d = pkt_cnt_q + LW'(wr_last) - LW'(rd_last);

        // A non-last beat leaving opens the drain; the last beat closes it.
        if (rd_en) drain_d = ~m_last_o;
        // Nothing left of the packet in the buffer: later beats are gated afresh.
        if (level_d == '0) drain_d = 1'b0;
    end

    // Control state register; reset discards everything stored.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_cnt_q <= '0;
            drain_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pkt_cnt_q <= pkt_cnt_d;
            drain_q   <= drain_d;
        end
    end

    // Beat storage; contents are meaningless outside [rd_ptr, wr_ptr) so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {s_last_i, s_id_i, s_data_i};
    end

endmodule

// File: tb/tb_xbar_egress_fifo.sv
// Bench for xbar_egress_fifo: one cut-through and one packet-mode instance,
// directed steps with a per-instance expected-beat queue.
module tb_xbar_egress_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic [7:0] c_s_data = '0, p_s_data = '0;
    logic [2:0] c_s_id = '0, p_s_id = '0;
    logic       c_s_last = 1'b0, p_s_last = 1'b0;
    logic       c_s_valid = 1'b0, p_s_valid = 1'b0;
    logic       c_m_ready = 1'b0, p_m_ready = 1'b0;
    logic       c_s_ready, p_s_ready;
    logic [7:0] c_m_data, p_m_data;
    logic [2:0] c_m_id, p_m_id;
    logic       c_m_last, p_m_last, c_m_valid, p_m_valid;
    logic [3:0] c_level, p_level, c_pkt, p_pkt;

    logic [11:0] c_q[$];
    logic [11:0] p_q[$];
    logic        c_acc, p_acc;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    xbar_egress_fifo #(.T_DATA_WIDTH(8), .T_ID___WIDTH(3), .DEPTH(8), .PACKET_MODE(0)) dut_ct (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(c_s_data), .s_id_i(c_s_id), .s_last_i(c_s_last),
        .s_valid_i(c_s_valid), .s_ready_o(c_s_ready),
        .m_data_o(c_m_data), .m_id_o(c_m_id), .m_last_o(c_m_last),
        .m_valid_o(c_m_valid), .m_ready_i(c_m_ready),
        .level_o(c_level), .pkt_cnt_o(c_pkt)
    );

    xbar_egress_fifo #(.T_DATA_WIDTH(8), .T_ID___WIDTH(3), .DEPTH(8), .PACKET_MODE(1)) dut_pk (
        .clk(clk), .rst_n(rst_n),
        .s_data_i(p_s_data), .s_id_i(p_s_id), .s_last_i(p_s_last),
        .s_valid_i(p_s_valid), .s_ready_o(p_s_ready),
        .m_data_o(p_m_data), .m_id_o(p_m_id), .m_last_o(p_m_last),
        .m_valid_o(p_m_valid), .m_ready_i(p_m_ready),
        .level_o(p_level), .pkt_cnt_o(p_pkt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int c_lasts();
        int n = 0;
        foreach (c_q[i]) if (c_q[i][11]) n++;
        return n;
    endfunction

    // One clock: record accepted beats, compare delivered beats, then advance.
    task automatic cyc();
        logic [11:0] e;
        #1;
        c_acc = c_s_valid && c_s_ready;
        p_acc = p_s_valid && p_s_ready;
        if (c_acc) c_q.push_back({c_s_last, c_s_id, c_s_data});
        if (p_acc) p_q.push_back({p_s_last, p_s_id, p_s_data});
        if (c_m_valid && c_m_ready) begin
            chk("c_pop_nonempty", 32'(c_q.size() != 0), 32'd1);
            if (c_q.size() != 0) begin
                e = c_q.pop_front();
                chk("c_head_beat", 32'({c_m_last, c_m_id, c_m_data}), 32'(e));
            end
        end
        if (p_m_valid && p_m_ready) begin
            chk("p_pop_nonempty", 32'(p_q.size() != 0), 32'd1);
            if (p_q.size() != 0) begin
                e = p_q.pop_front();
                chk("p_head_beat", 32'({p_m_last, p_m_id, p_m_data}), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain_c(input int budget);
        int n = 0;
        while ((c_q.size() != 0 || c_level != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("c_drain_level", 32'(c_level), 32'd0);
        chk("c_drain_queue", 32'(c_q.size()), 32'd0);
    endtask

    task automatic drain_p(input int budget);
        int n = 0;
        while ((p_q.size() != 0 || p_level != 0) && n < budget) begin
            cyc();
            n++;
        end
        chk("p_drain_level", 32'(p_level), 32'd0);
        chk("p_drain_queue", 32'(p_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int n;

        // reset state
        cyc();
        cyc();
        chk("rst_c_level", 32'(c_level), 32'd0);
        chk("rst_p_level", 32'(p_level), 32'd0);
        chk("rst_p_pkt", 32'(p_pkt), 32'd0);
        chk("rst_c_mvalid", 32'(c_m_valid), 32'd0);
        chk("rst_p_mvalid", 32'(p_m_valid), 32'd0);
        chk("rst_c_sready", 32'(c_s_ready), 32'd0);
        chk("rst_p_sready", 32'(p_s_ready), 32'd0);
        rst_n = 1'b0;
        cyc();
        chk("rel_c_sready", 32'(c_s_ready), 32'd1);
        chk("rel_p_sready", 32'(p_s_ready), 32'd1);

        // T1 cut-through single beat
        c_m_ready = 1'b1;
        c_s_valid = 1'b1; c_s_data = 8'hF0; c_s_id = 3'd2; c_s_last = 1'b1;
        cyc();
        c_s_valid = 1'b0;
        chk("t1_mvalid", 32'(c_m_valid), 32'd1);
        chk("t1_mdata", 32'(c_m_data), 32'hF0);
        chk("t1_mid", 32'(c_m_id), 32'd2);
        chk("t1_mlast", 32'(c_m_last), 32'd1);
        chk("t1_level", 32'(c_level), 32'd1);
        chk("t1_pkt", 32'(c_pkt), 32'd1);
        cyc();
        chk("t1_level_after", 32'(c_level), 32'd0);
        chk("t1_mvalid_after", 32'(c_m_valid), 32'd0);

        // T2 fill to full, overflow attempt, ordered drain
        c_m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_s_valid = 1'b1; c_s_data = 8'(i); c_s_id = 3'(i); c_s_last = 1'b0;
            cyc();
        end
        chk("t2_level_full", 32'(c_level), 32'd8);
        chk("t2_sready_full", 32'(c_s_ready), 32'd0);
        chk("t2_head_stable", 32'(c_m_data), 32'h00);
        chk("t2_mvalid", 32'(c_m_valid), 32'd1);
        c_s_data = 8'h08; c_s_id = 3'd0;
        cyc();
        chk("t2_level_ninth", 32'(c_level), 32'd8);
        c_s_valid = 1'b0;
        c_m_ready = 1'b1;
        cyc();
        chk("t2_sready_after_read", 32'(c_s_ready), 32'd1);
        chk("t2_level_after_read", 32'(c_level), 32'd7);
        drain_c(20);

        // T5 simultaneous write+read at level 4
        c_m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c_s_valid = 1'b1; c_s_data = 8'h50 + 8'(i); c_s_id = 3'd3; c_s_last = (i % 2) == 1;
            cyc();
        end
        chk("t5_level_pre", 32'(c_level), 32'd4);
        chk("t5_pkt_pre", 32'(c_pkt), 32'd2);
        c_m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            c_s_valid = 1'b1; c_s_data = 8'h60 + 8'(i); c_s_id = 3'(i); c_s_last = (i % 3) == 0;
            cyc();
            chk("t5_level_hold", 32'(c_level), 32'd4);
            chk("t5_pkt_track", 32'(c_pkt), 32'(c_lasts()));
        end
        c_s_valid = 1'b0;
        drain_c(20);
        chk("t5_pkt_end", 32'(c_pkt), 32'd0);

        // T3 packet gating
        p_m_ready = 1'b1;
        p_s_valid = 1'b1; p_s_data = 8'hA1; p_s_id = 3'd5; p_s_last = 1'b0;
        cyc();
        chk("t3_gate_1", 32'(p_m_valid), 32'd0);
        chk("t3_level_1", 32'(p_level), 32'd1);
        chk("t3_pkt_0", 32'(p_pkt), 32'd0);
        p_s_data = 8'hA2;
        cyc();
        chk("t3_gate_2", 32'(p_m_valid), 32'd0);
        p_s_data = 8'hA3; p_s_last = 1'b1;
        cyc();
        p_s_valid = 1'b0;
        chk("t3_open", 32'(p_m_valid), 32'd1);
        chk("t3_pkt_1", 32'(p_pkt), 32'd1);
        chk("t3_first", 32'(p_m_data), 32'hA1);
        cyc();
        chk("t3_hold", 32'(p_m_valid), 32'd1);
        cyc();
        cyc();
        chk("t3_level_end", 32'(p_level), 32'd0);
        chk("t3_pkt_end", 32'(p_pkt), 32'd0);
        chk("t3_mvalid_end", 32'(p_m_valid), 32'd0);

        // T4 oversize packet falls back to cut-through when full
        p_m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            p_s_valid = 1'b1; p_s_data = 8'h10 + 8'(i); p_s_id = 3'd1; p_s_last = 1'b0;
            chk("t4_gated", 32'(p_m_valid), 32'd0);
            cyc();
        end
        chk("t4_level_full", 32'(p_level), 32'd8);
        chk("t4_open_full", 32'(p_m_valid), 32'd1);
        chk("t4_sready_full", 32'(p_s_ready), 32'd0);
        idx = 8;
        n = 0;
        while (idx < 10 && n < 20) begin
            p_s_valid = 1'b1; p_s_data = 8'h10 + 8'(idx); p_s_id = 3'd1; p_s_last = 1'b0;
            cyc();
            if (p_acc) idx++;
            n++;
        end
        chk("t4_all_written", 32'(idx), 32'd10);
        p_s_valid = 1'b0;
        drain_p(30);

        // T6 reset mid-packet
        p_m_ready = 1'b0;
        p_s_valid = 1'b1; p_s_data = 8'hB1; p_s_id = 3'd4; p_s_last = 1'b0;
        cyc();
        p_s_data = 8'hB2;
        cyc();
        p_s_valid = 1'b0;
        chk("t6_level_pre", 32'(p_level), 32'd2);
        rst_n = 1'b1;
        cyc();
        c_q.delete();
        p_q.delete();
        chk("t6_level_rst", 32'(p_level), 32'd0);
        chk("t6_pkt_rst", 32'(p_pkt), 32'd0);
        chk("t6_mvalid_rst", 32'(p_m_valid), 32'd0);
        chk("t6_sready_rst", 32'(p_s_ready), 32'd0);
        rst_n = 1'b0;
        cyc();
        chk("t6_sready_rel", 32'(p_s_ready), 32'd1);
        p_m_ready = 1'b1;
        p_s_valid = 1'b1; p_s_data = 8'hC1; p_s_id = 3'd6; p_s_last = 1'b0;
        cyc();
        p_s_data = 8'hC2; p_s_last = 1'b1;
        cyc();
        p_s_valid = 1'b0;
        chk("t6_open", 32'(p_m_valid), 32'd1);
        chk("t6_first", 32'(p_m_data), 32'hC1);
        drain_p(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
